// File: rtl/ppe_pkg.sv
// Shared packet layout, opcodes and widths for the stream partial processing element.
package ppe_pkg;

  localparam int unsigned ADDR_MSB        = 32;
  localparam int unsigned ADDR_LSB        = 29;
  localparam int unsigned OP_MSB          = 28;
  localparam int unsigned OP_LSB          = 25;
  localparam int unsigned DATA_MSB        = 24;

  localparam int unsigned PKT_W           = 33;
  localparam int unsigned WEIGHT_W        = 8;
  localparam int unsigned PSUM_W          = 13;
  localparam int unsigned WEIGHTS_PER_PKT = 3;

  localparam logic [3:0] OP_WEIGHT   = 4'd0;
  localparam logic [3:0] OP_INPUT    = 4'd1;
  localparam logic [3:0] OP_PSUM     = 4'd2;
  localparam logic [3:0] OP_TIMESTEP = 4'd15;

  typedef struct packed {
    logic [ADDR_MSB-ADDR_LSB:0] addr;
    logic [OP_MSB-OP_LSB:0]     opcode;
    logic [DATA_MSB:0]          data;
  } packet_t;

  function automatic packet_t make_pkt(input logic [3:0] addr, input logic [3:0] opcode,
                                       input logic [DATA_MSB:0] data);
    packet_t p;
    p.addr   = addr;
    p.opcode = opcode;
    p.data   = data;
    return p;
  endfunction

endpackage

// File: rtl/ppe_col_mac.sv
// One output column: sum of the weights whose aligned spike bit is set.
module ppe_col_mac
  import ppe_pkg::*;
#(
  parameter int unsigned FILTER_W = 5
) (
  input  logic [FILTER_W-1:0]               spk,
  input  logic [FILTER_W-1:0][WEIGHT_W-1:0] w,
  output logic [PSUM_W-1:0]                 psum
);

  always_comb begin
    psum = '0;
    for (int k = 0; k < int'(FILTER_W); k++) begin
      if (spk[k]) psum = psum + PSUM_W'(w[k]);
    end
  end

endmodule

// File: rtl/ppe_stream.sv
// Stream partial processing element: loads a filter row, convolves spike rows
// against it and emits one psum packet per output column over valid/ready.
module ppe_stream
  import ppe_pkg::*;
#(
  parameter logic [3:0]  MY_ADDR   = 4'd5,
  parameter logic [3:0]  DEST_ADDR = 4'd6,
  parameter int unsigned FILTER_W  = 5,
  parameter int unsigned IFMAP_W   = 25,
  parameter bit          SKIP_ZERO = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PKT_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PKT_W-1:0] out_data,
  output logic             weights_loaded,
  output logic [7:0]       drop_cnt,
  output logic             err_no_weights
);

  localparam int unsigned OUT_W = IFMAP_W - FILTER_W + 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] TS_SEND = 2'd2;

  logic [1:0]                        state_q, state_d;
  logic                              rdy_q, rdy_d;
  logic [FILTER_W-1:0][WEIGHT_W-1:0] w_q, w_d;
  logic [4:0]                        wptr_q, wptr_d;
  logic                              wl_q, wl_d;
  logic [IFMAP_W-1:0]                spikes_q, spikes_d;
  logic [4:0]                        col_q, col_d;
  logic [3:0]                        row_q, row_d;
  logic                              ov_q, ov_d;
  packet_t                           od_q, od_d;
  logic [7:0]                        drop_q, drop_d;
  logic                              err_q, err_d;

  logic [3:0]          in_addr;
  logic [3:0]          in_op;
  logic [DATA_MSB:0]   in_pl;
  logic                accept;
  logic                out_free;
  logic                op_legal;
  logic [5:0]          nptr;
  logic [FILTER_W-1:0] win;
  logic [PSUM_W-1:0]   psum;

  assign in_addr  = in_data[ADDR_MSB:ADDR_LSB];
  assign in_op    = in_data[OP_MSB:OP_LSB];
  assign in_pl    = in_data[DATA_MSB:0];
  assign accept   = in_valid && rdy_q;
  assign out_free = !ov_q || out_ready;
  assign op_legal = (in_op == OP_WEIGHT) || (in_op == OP_INPUT) || (in_op == OP_TIMESTEP);
  assign nptr     = 6'(wptr_q) + 6'(WEIGHTS_PER_PKT);
  assign win      = FILTER_W'(spikes_q >> col_q);

  ppe_col_mac #(.FILTER_W(FILTER_W)) u_mac (
    .spk  (win),
    .w    (w_q),
    .psum (psum)
  );

  // Next-state, datapath and output register update.
  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    wptr_d   = wptr_q;
    wl_d     = wl_q;
    spikes_d = spikes_q;
    col_d    = col_q;
    row_d    = row_q;
    ov_d     = ov_q && !out_ready;
    od_d     = od_q;
    drop_d   = drop_q;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if ((in_addr != MY_ADDR) || !op_legal) begin
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
          end else if (in_op == OP_WEIGHT) begin
            if (wptr_q == 5'd0) wl_d = 1'b0;
            for (int k = 0; k < int'(FILTER_W); k++) begin
              for (int i = 0; i < int'(WEIGHTS_PER_PKT); i++) begin
                if (int'(wptr_q) + i == k) w_d[k] = in_pl[8*i +: 8];
              end
            end
            if (nptr >= 6'(FILTER_W)) begin
              wl_d   = 1'b1;
              wptr_d = 5'd0;
            end else begin
              wptr_d = 5'(nptr);
            end
          end else if (in_op == OP_INPUT) begin
            if (!wl_q) begin
              err_d = 1'b1;
            end else begin
              spikes_d = in_pl[IFMAP_W-1:0];
              col_d    = 5'd0;
              state_d  = COMPUTE;
            end
          end else begin
            state_d = TS_SEND;
          end
        end
      end

      COMPUTE: begin
        if (out_free) begin
          if (!SKIP_ZERO || (psum != '0)) begin
            ov_d = 1'b1;
            od_d = make_pkt(DEST_ADDR, OP_PSUM, {row_q, col_q, 16'(psum)});
          end
          col_d = col_q + 5'd1;
          if (col_q == 5'(OUT_W - 1)) begin
            row_d   = row_q + 4'd1;
            state_d = IDLE;
          end
        end
      end

      TS_SEND: begin
        if (out_free) begin
          ov_d    = 1'b1;
          od_d    = make_pkt(DEST_ADDR, OP_TIMESTEP, 25'd0);
          row_d   = 4'd0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    rdy_d = (state_d == IDLE);
  end

  // Reset discards weights and aborts any row in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rdy_q    <= 1'b0;
      w_q      <= '0;
      wptr_q   <= 5'd0;
      wl_q     <= 1'b0;
      spikes_q <= '0;
      col_q    <= 5'd0;
      row_q    <= 4'd0;
      ov_q     <= 1'b0;
      od_q     <= '0;
      drop_q   <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= rdy_d;
      w_q      <= w_d;
      wptr_q   <= wptr_d;
      wl_q     <= wl_d;
      spikes_q <= spikes_d;
      col_q    <= col_d;
      row_q    <= row_d;
      ov_q     <= ov_d;
      od_q     <= od_d;
      drop_q   <= drop_d;
      err_q    <= err_d;
    end
  end

  assign in_ready       = rdy_q;
  assign out_valid      = ov_q;
  assign out_data       = od_q;
  assign weights_loaded = wl_q;
  assign drop_cnt       = drop_q;
  assign err_no_weights = err_q;

endmodule

// File: tb/tb_ppe_stream.sv
// Scoreboard bench for ppe_stream: directed packets, expected psum packets queued
// at issue time and popped by an independent output monitor.
module tb_ppe_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [32:0] in_data = '0;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] out_data;
  logic        weights_loaded;
  logic [7:0]  drop_cnt;
  logic        err_no_weights;

  logic        sz_in_valid = 1'b0;
  logic        sz_in_ready;
  logic [32:0] sz_in_data = '0;
  logic        sz_out_valid;
  logic [32:0] sz_out_data;
  logic        sz_wl;
  logic [7:0]  sz_drop;
  logic        sz_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [32:0] q[$];
  bit          mon_en = 1'b1;
  bit          tog_en = 1'b0;

  localparam logic [32:0] W1     = {4'd5, 4'd0, 1'b0, 8'd3, 8'd2, 8'd1};
  localparam logic [32:0] W2     = {4'd5, 4'd0, 1'b0, 8'hEE, 8'd5, 8'd4};
  localparam logic [32:0] ROW_A  = {4'd5, 4'd1, 25'h0AAAAAA};
  localparam logic [32:0] ROW_Z  = {4'd5, 4'd1, 25'h0};
  localparam logic [32:0] TS     = {4'd5, 4'd15, 25'h0};
  localparam logic [32:0] TS_OUT = {4'd6, 4'd15, 25'h0};

  always #5 clk = ~clk;

  ppe_stream dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .weights_loaded (weights_loaded),
    .drop_cnt       (drop_cnt),
    .err_no_weights (err_no_weights)
  );

  ppe_stream #(.SKIP_ZERO(1'b1)) dut_sz (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (sz_in_valid),
    .in_ready       (sz_in_ready),
    .in_data        (sz_in_data),
    .out_valid      (sz_out_valid),
    .out_ready      (1'b1),
    .out_data       (sz_out_data),
    .weights_loaded (sz_wl),
    .drop_cnt       (sz_drop),
    .err_no_weights (sz_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] psum_pkt(input logic [3:0] r, input logic [4:0] c,
                                           input logic [15:0] p);
    return {4'd6, 4'd2, r, c, p};
  endfunction

  task automatic push_row(input logic [3:0] r, input logic [15:0] pe, input logic [15:0] po);
    for (int c = 0; c < 21; c++) q.push_back(psum_pkt(r, 5'(c), (c % 2 == 0) ? pe : po));
  endtask

  task automatic send(input bit sel, input logic [32:0] p);
    int  n;
    logic rdy;
    n = 0;
    @(posedge clk); #1;
    if (sel) begin sz_in_valid = 1'b1; sz_in_data = p; end
    else     begin in_valid    = 1'b1; in_data    = p; end
    do begin
      @(negedge clk);
      n++;
      rdy = sel ? sz_in_ready : in_ready;
    end while (!rdy && n < 300);
    chk("send_accept", 64'(rdy), 64'd1);
    @(posedge clk); #1;
    if (sel) sz_in_valid = 1'b0;
    else     in_valid    = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", 64'(q.size()), 64'd0);
  endtask

  // Downstream ready: held high, or toggled every cycle while tog_en is set.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = tog_en ? ~out_ready : 1'b1;
    end
  end

  // Output monitor: pops the scoreboard on each transfer and checks hold stability.
  initial begin
    logic [32:0] held;
    bit          held_v;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (!mon_en || rst) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          chk("hold_valid", 64'(out_valid), 64'd1);
          chk("hold_data", 64'(out_data), 64'(held));
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_out: got %0h expected no packet", out_data);
          end else begin
            chk("out_pkt", 64'(out_data), 64'(q.pop_front()));
          end
        end
        held_v = out_valid && !out_ready;
        held   = out_data;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, ov_seen, first, last, n;
    logic [32:0] sz_first;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_weights_loaded", 64'(weights_loaded), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_err", 64'(err_no_weights), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Spike row before any weights
    send(1'b0, ROW_A);
    cnt = 0; ov_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (err_no_weights) cnt++;
      if (out_valid) ov_seen++;
    end
    chk("err_pulse_count", 64'(cnt), 64'd1);
    chk("err_no_output", 64'(ov_seen), 64'd0);
    chk("err_drop_cnt", 64'(drop_cnt), 64'd0);

    send(1'b0, {4'd3, 4'd0, 25'h1});
    @(negedge clk);
    chk("drop_addr", 64'(drop_cnt), 64'd1);
    send(1'b0, {4'd5, 4'd7, 25'h0});
    @(negedge clk);
    chk("drop_opcode", 64'(drop_cnt), 64'd2);

    send(1'b0, W1);
    @(negedge clk);
    chk("wl_after_first", 64'(weights_loaded), 64'd0);
    send(1'b0, W2);
    @(negedge clk);
    chk("wl_after_second", 64'(weights_loaded), 64'd1);

    // Alternating row, weights 1..5: even col = 2+4, odd col = 1+3+5
    push_row(4'd0, 16'd6, 16'd9);
    send(1'b0, ROW_A);
    cnt = 0; first = -1; last = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (first < 0) first = i;
        last = i;
        cnt++;
      end
    end
    chk("row0_count", 64'(cnt), 64'd21);
    chk("row0_span", 64'(last - first), 64'd20);

    push_row(4'd1, 16'd6, 16'd9);
    send(1'b0, ROW_A);
    push_row(4'd2, 16'd0, 16'd0);
    send(1'b0, ROW_Z);
    drain();

    tog_en = 1'b1;
    push_row(4'd3, 16'd6, 16'd9);
    send(1'b0, ROW_A);
    drain();
    tog_en = 1'b0;

    // Timestep queued behind a row, then row tagging restarts
    push_row(4'd4, 16'd6, 16'd9);
    send(1'b0, ROW_A);
    q.push_back(TS_OUT);
    send(1'b0, TS);
    push_row(4'd0, 16'd6, 16'd9);
    send(1'b0, ROW_A);
    drain();

    // Reset in the middle of a row
    mon_en = 1'b0;
    send(1'b0, ROW_A);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_weights_loaded", 64'(weights_loaded), 64'd0);
    chk("midrst_drop_cnt", 64'(drop_cnt), 64'd0);
    mon_en = 1'b1;
    send(1'b0, ROW_A);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (err_no_weights) cnt++;
    end
    chk("midrst_err_pulse", 64'(cnt), 64'd1);

    // Zero suppression instance
    send(1'b1, W1);
    send(1'b1, W2);
    @(negedge clk);
    chk("sz_wl", 64'(sz_wl), 64'd1);
    send(1'b1, ROW_Z);
    n = 0; ov_seen = 0;
    do begin
      @(negedge clk);
      n++;
      if (sz_out_valid) ov_seen++;
    end while (!sz_in_ready && n < 60);
    chk("sz_zero_outputs", 64'(ov_seen), 64'd0);
    chk("sz_idle_after", 64'(n), 64'd22);
    send(1'b1, ROW_A);
    cnt = 0; sz_first = '0;
    repeat (40) begin
      @(negedge clk);
      if (sz_out_valid) begin
        if (cnt == 0) sz_first = sz_out_data;
        cnt++;
      end
    end
    chk("sz_nonzero_count", 64'(cnt), 64'd21);
    chk("sz_first_pkt", 64'(sz_first), 64'(psum_pkt(4'd1, 5'd0, 16'd6)));
    chk("sz_drop", 64'(sz_drop), 64'd0);
    chk("sz_err", 64'(sz_err), 64'd0);

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
